soc_miner_mem_rd_arbiter: RTL and testbench
===========================================

# soc_miner_mem_rd_arbiter

Round-robin arbiter that shares the single 64-bit AXI3 memory master port of `soc_miner` among up to `NUM_REQ` internal read clients, for example the work-fetch and midstate-fetch engines. It accepts one burst request per grant and issues it on the AR channel with the requester index as ARID. It steers the R-channel beats back to the granted client and keeps one burst outstanding at a time. The block sits between the miner cores and the `m_memory_ar*`/`m_memory_r*` ports.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `MEMORY_DATA_WIDTH`, 64: R data width.
- `MEMORY_ADDR_WIDTH`, 32: AR address width.
- `MEMORY_BUS_LEN_WIDTH`, 4: ARLEN width (AXI3, beats = len+1).
- `MEMORY_ID_WIDTH`, 6: ARID/RID width.

Ports:
- `Clk` in 1: single clock.
- `Rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-client burst request.
- `req_ready` out NUM_REQ: request accepted (one-hot, at most one bit set).
- `req_addr` in NUM_REQ*ADDR: client i at slice i, must be 8-byte aligned.
- `req_len` in NUM_REQ*LEN: client i ARLEN value.
- `rsp_valid` out NUM_REQ: beat valid for client i.
- `rsp_ready` in NUM_REQ: client i accepts beat.
- `rsp_data` out DATA: shared beat data.
- `rsp_last` out 1: shared last-beat flag.
- `rsp_resp` out 2: shared RRESP.
- `m_memory_arvalid` out 1, `m_memory_arready` in 1: AR handshake.
- `m_memory_araddr` out ADDR: burst address.
- `m_memory_arlen` out LEN: burst length.
- `m_memory_arid` out ID: burst ID.
- `m_memory_arsize` out 3: constant 3'b011.
- `m_memory_arburst` out 2: constant 2'b01 (INCR).
- `m_memory_arlock` out 2: constant 0.
- `m_memory_arcache` out 4: constant 4'b0011.
- `m_memory_arprot` out 3: constant 0.
- `m_memory_arqos` out 4: constant 0.
- `m_memory_rvalid` in 1, `m_memory_rready` out 1: R handshake.
- `m_memory_rdata` in DATA, `m_memory_rlast` in 1, `m_memory_rresp` in 2, `m_memory_rid` in ID: R channel.
- `err_sticky` out 3: bit0 = RRESP!=OKAY, bit1 = RID mismatch, bit2 = RLAST/length mismatch.
- `err_clr` in 1: synchronous clear of `err_sticky`.

## Operation
- States are IDLE, ADDR and DATA.
- **IDLE:** scan `req_valid` starting at `rr_ptr`, wrapping modulo NUM_REQ; the first set bit is the winner.
  - `req_ready[winner]` is driven combinationally in the same cycle.
  - On that cycle the block latches `grant`, `addr`, `len` and clears `beat_cnt`, then moves to ADDR.
  - With no `req_valid` set, it stays in IDLE.
- **ADDR:** `m_memory_arvalid`=1 with the latched fields held stable, and `arid` = grant zero-extended.
  - On `arready`, move to DATA.
- **DATA:** `rsp_valid[grant]` = `m_memory_rvalid`, all other `rsp_valid` bits are 0, and `m_memory_rready` = `rsp_ready[grant]`.
  - `rsp_data`, `rsp_last` and `rsp_resp` pass through combinationally.
  - Each R handshake increments `beat_cnt`.
  - On a handshake with `rlast`=1, return to IDLE and set `rr_ptr` = (grant+1) mod NUM_REQ.
- **Error flags:**
  - bit0 sets on any handshake with `rresp` != 0.
  - bit1 sets on any handshake with `rid` != grant; the beat is still routed to `grant`.
  - bit2 sets when `rlast`=1 with `beat_cnt` != len, or when `rlast`=0 with `beat_cnt` == len. For early `rlast`, the burst still terminates on `rlast`. For late `rlast`, the FSM waits for it.
- **Clear vs. set:** `err_clr` has priority over sets in the same cycle.
- **Unsolicited beats:** `rvalid` in IDLE or ADDR is not accepted (`rready`=0).
- **Widths:** `beat_cnt` is LEN bits wide and compares against the latched `len`. `rr_ptr` and `grant` are clog2(NUM_REQ) bits.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, `grant`=0, and `err_sticky`=0.
  - All valid, ready and AR outputs are 0, apart from the constants.
  - Reset may arrive mid-burst; the block does not drain the outstanding burst, and the system resets the interconnect together with it.
- **Latency:** the request is accepted in cycle T, and `arvalid` first goes high in T+1. The first beat can be delivered in the cycle after AR is accepted, at the earliest.
- **Back-to-back bursts:** after the last-beat handshake in cycle T, the next request can be accepted in T+1. The minimum gap between bursts is one IDLE cycle.
- **Stability:** AR outputs hold while `arvalid`=1 and `arready`=0. `req_valid` may drop without acceptance, and the block does not require clients to hold it.
- **Fairness:** a client that holds `req_valid` is granted within NUM_REQ bursts.

## Test plan
- **Single request:** client 2 requests addr 0x1000_0040, len 3 → one AR with id 2 and len 3; four beats appear only on `rsp_valid[2]`; `rsp_last` on beat 4; then IDLE.
- **Round robin:** all four clients hold `req_valid` from reset → grants in order 0,1,2,3,0; each `arid` matches its grant.
- **Backpressure:** hold `arready` low for 5 cycles → AR fields stay stable. Toggle `rsp_ready[1]` 1/0 → `m_memory_rready` follows it; no beats lost or duplicated; data order preserved.
- **Errors:**
  - RRESP=2 on beat 2 → `err_sticky`=3'b001.
  - RID=5 while grant=0 → bit1 set.
  - `rlast` on beat 2 with len=3 → bit2 set, FSM back in IDLE.
  - `err_clr` → 0.
- **Reset mid-burst:** assert `Rst_n`=0 during DATA beat 1 → all outputs 0 asynchronously. After release, a client 3 request gets grant 3 via the scan from `rr_ptr`=0.

Source files
------------

// File: rtl/soc_miner_mem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// soc_miner_mem_rd_arbiter
//
// Shares the single AXI3 read master port of soc_miner among NUM_REQ internal
// read clients. A round-robin scan picks one burst request and issues it on
// AR with the client index as ARID. The R beats are then steered back to that
// client. Only one burst is outstanding at a time.
//
// Ports
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-client burst request handshake (ready one-hot)
//   req_addr/req_len    : per-client burst address / ARLEN, client i at slice i
//   rsp_valid/rsp_ready : per-client beat handshake
//   rsp_data/last/resp  : shared beat payload, passed through from R channel
//   m_memory_ar*        : AXI3 read address channel (master side)
//   m_memory_r*         : AXI3 read data channel (master side)
//   err_sticky          : bit0 RRESP!=OKAY, bit1 RID mismatch, bit2 RLAST/len
//   err_clr             : synchronous clear of err_sticky (wins over sets)
// -----------------------------------------------------------------------------
module soc_miner_mem_rd_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int MEMORY_DATA_WIDTH    = 64,
  parameter int MEMORY_ADDR_WIDTH    = 32,
  parameter int MEMORY_BUS_LEN_WIDTH = 4,
  parameter int MEMORY_ID_WIDTH      = 6
) (
  input  logic                                    Clk,
  input  logic                                    Rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*MEMORY_ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*MEMORY_BUS_LEN_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  input  logic [NUM_REQ-1:0]                      rsp_ready,
  output logic [MEMORY_DATA_WIDTH-1:0]            rsp_data,
  output logic                                    rsp_last,
  output logic [1:0]                              rsp_resp,
  output logic                                    m_memory_arvalid,
  input  logic                                    m_memory_arready,
  output logic [MEMORY_ADDR_WIDTH-1:0]            m_memory_araddr,
  output logic [MEMORY_BUS_LEN_WIDTH-1:0]         m_memory_arlen,
  output logic [MEMORY_ID_WIDTH-1:0]              m_memory_arid,
  output logic [2:0]                              m_memory_arsize,
  output logic [1:0]                              m_memory_arburst,
  output logic [1:0]                              m_memory_arlock,
  output logic [3:0]                              m_memory_arcache,
  output logic [2:0]                              m_memory_arprot,
  output logic [3:0]                              m_memory_arqos,
  input  logic                                    m_memory_rvalid,
  output logic                                    m_memory_rready,
  input  logic [MEMORY_DATA_WIDTH-1:0]            m_memory_rdata,
  input  logic                                    m_memory_rlast,
  input  logic [1:0]                              m_memory_rresp,
  input  logic [MEMORY_ID_WIDTH-1:0]              m_memory_rid,
  output logic [2:0]                              err_sticky,
  input  logic                                    err_clr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = MEMORY_ADDR_WIDTH;
  localparam int LW    = MEMORY_BUS_LEN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_grant;
  logic [AW-1:0]    r_addr;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_beat_cnt;
  logic [2:0]       r_err;

  logic [PTR_W-1:0] w_winner;
  logic [PTR_W-1:0] w_scan_idx;
  logic             w_found;
  logic             w_accept;
  logic [AW-1:0]    w_sel_addr;
  logic [LW-1:0]    w_sel_len;
  logic             w_r_hs;
  logic             w_last_hs;
  logic [2:0]       w_err_set;

  // Round-robin scan: first requesting client at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan_idx = PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Select the winner's address/length slices with constant indices only.
  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == PTR_W'(i)) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_len  = req_len[i*LW +: LW];
      end else begin
        w_sel_len  = w_sel_len;
      end
    end
  end

  assign w_accept  = (r_state == ST_IDLE) && w_found;
  assign w_r_hs    = (r_state == ST_DATA) && m_memory_rvalid && rsp_ready[r_grant];
  assign w_last_hs = w_r_hs && m_memory_rlast;

  // Per-client handshake outputs; beats are only routed while in DATA.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_accept && (w_winner == PTR_W'(i));
      rsp_valid[i] = (r_state == ST_DATA) && m_memory_rvalid && (r_grant == PTR_W'(i));
    end
  end

  assign m_memory_rready  = (r_state == ST_DATA) && rsp_ready[r_grant];
  assign rsp_data         = m_memory_rdata;
  assign rsp_last         = m_memory_rlast;
  assign rsp_resp         = m_memory_rresp;

  assign m_memory_arvalid = (r_state == ST_ADDR);
  assign m_memory_araddr  = r_addr;
  assign m_memory_arlen   = r_len;
  assign m_memory_arid    = MEMORY_ID_WIDTH'(r_grant);
  assign m_memory_arsize  = 3'b011;
  assign m_memory_arburst = 2'b01;
  assign m_memory_arlock  = 2'b00;
  assign m_memory_arcache = 4'b0011;
  assign m_memory_arprot  = 3'b000;
  assign m_memory_arqos   = 4'b0000;
  assign err_sticky       = r_err;

  // Next-state logic; a burst always ends on RLAST, even when the count disagrees.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ADDR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (m_memory_arready) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (w_last_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst context: grant/addr/len latched on accept, beat counter, rr pointer.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_grant    <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_grant    <= w_winner;
        r_addr     <= w_sel_addr;
        r_len      <= w_sel_len;
        r_beat_cnt <= '0;
      end else if (w_r_hs) begin
        r_beat_cnt <= r_beat_cnt + LW'(1);
      end
      if (w_last_hs) begin
        r_rr_ptr <= (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : (r_grant + PTR_W'(1));
      end
    end
  end

  // Error events on each accepted beat; a late or early RLAST flags bit2.
  always_comb begin
    w_err_set    = 3'b000;
    w_err_set[0] = w_r_hs && (m_memory_rresp != 2'b00);
    w_err_set[1] = w_r_hs && (m_memory_rid != MEMORY_ID_WIDTH'(r_grant));
    w_err_set[2] = w_r_hs && (m_memory_rlast ? (r_beat_cnt != r_len)
                                             : (r_beat_cnt == r_len));
  end

  // Sticky error flags; clear takes priority over a same-cycle set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_err <= 3'b000;
    end else if (err_clr) begin
      r_err <= 3'b000;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

endmodule

// File: tb/tb_soc_miner_mem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for soc_miner_mem_rd_arbiter: a transaction-level model of the arbiter
// (phase, granted client, expected beat count, rr pointer, sticky flags) is
// stepped every clock and compared against the DUT each cycle, with directed
// scenarios carrying literal expectations followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_soc_miner_mem_rd_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_addr;
  logic [15:0]  req_len;
  logic [63:0]  rsp_data;
  logic         rsp_last;
  logic [1:0]   rsp_resp;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [5:0]   arid;
  logic [2:0]   arsize;
  logic [1:0]   arburst, arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic [3:0]   arqos;
  logic         rvalid, rready;
  logic [63:0]  rdata;
  logic         rlast;
  logic [1:0]   rresp;
  logic [5:0]   rid;
  logic [2:0]   err_sticky;
  logic         err_clr;

  int checks = 0;
  int errors = 0;

  // model state: phase 0=waiting for request, 1=address pending, 2=receiving
  int          m_phase, m_grant, m_len, m_beats, m_ptr;
  logic [31:0] m_addr;
  logic [2:0]  m_err;

  soc_miner_mem_rd_arbiter dut (
    .Clk(clk), .Rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_resp(rsp_resp),
    .m_memory_arvalid(arvalid), .m_memory_arready(arready),
    .m_memory_araddr(araddr), .m_memory_arlen(arlen), .m_memory_arid(arid),
    .m_memory_arsize(arsize), .m_memory_arburst(arburst),
    .m_memory_arlock(arlock), .m_memory_arcache(arcache),
    .m_memory_arprot(arprot), .m_memory_arqos(arqos),
    .m_memory_rvalid(rvalid), .m_memory_rready(rready),
    .m_memory_rdata(rdata), .m_memory_rlast(rlast),
    .m_memory_rresp(rresp), .m_memory_rid(rid),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int w;
    w = rr_pick(req_valid, m_ptr);
    chk("req_ready", req_ready, (m_phase == 0 && w >= 0) ? (64'd1 << w) : 64'd0);
    chk("arvalid", arvalid, (m_phase == 1) ? 64'd1 : 64'd0);
    if (m_phase == 1) begin
      chk("araddr", araddr, m_addr);
      chk("arlen", arlen, m_len);
      chk("arid", arid, m_grant);
    end
    chk("rsp_valid", rsp_valid, (m_phase == 2 && rvalid) ? (64'd1 << m_grant) : 64'd0);
    chk("rready", rready, (m_phase == 2) ? rsp_ready[m_grant] : 1'b0);
    if (m_phase == 2 && rvalid) begin
      chk("rsp_data", rsp_data, rdata);
      chk("rsp_last", rsp_last, rlast);
      chk("rsp_resp", rsp_resp, rresp);
    end
    chk("err_sticky", err_sticky, m_err);
  endtask

  task automatic update_model();
    int w;
    logic [2:0] set;
    set = 3'b000;
    case (m_phase)
      0: begin
        w = rr_pick(req_valid, m_ptr);
        if (w >= 0) begin
          m_grant = w;
          m_addr  = req_addr[w*32 +: 32];
          m_len   = int'(req_len[w*4 +: 4]);
          m_beats = 0;
          m_phase = 1;
        end
      end
      1: if (arready) m_phase = 2;
      default: begin
        if (rvalid && rsp_ready[m_grant]) begin
          set[0] = (rresp != 2'b00);
          set[1] = (int'(rid) != m_grant);
          set[2] = (rlast != ((m_beats % 16) == m_len));
          m_beats++;
          if (rlast) begin
            m_phase = 0;
            m_ptr   = (m_grant + 1) % N;
          end
        end
      end
    endcase
    m_err = err_clr ? 3'b000 : (m_err | set);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0;
    rresp = 2'b00; rid = '0; err_clr = 1'b0;
  endtask

  // Asserts reset asynchronously (inputs left as they were) and checks outputs.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 64'd0);
    chk("rst_rsp_valid", rsp_valid, 64'd0);
    chk("rst_rready", rready, 64'd0);
    chk("rst_arvalid", arvalid, 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_arlen", arlen, 64'd0);
    chk("rst_arid", arid, 64'd0);
    chk("rst_err", err_sticky, 64'd0);
    idle_inputs();
    m_phase = 0; m_grant = 0; m_ptr = 0; m_err = 3'b000; m_beats = 0; m_len = 0; m_addr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_burst(input int c, input logic [31:0] addr, input int len,
                           input int nbeats, input int resp_at, input int rid_at);
    req_valid = 4'd0;
    req_valid[c] = 1'b1;
    req_addr[c*32 +: 32] = addr;
    req_len[c*4 +: 4] = 4'(len);
    arready = 1'b1;
    rsp_ready = 4'hF;
    #1;
    chk("burst_accept", req_ready, 64'd1 << c);
    cycle();
    req_valid = 4'd0;
    chk("burst_arid", arid, c);
    chk("burst_arlen", arlen, len);
    chk("burst_araddr", araddr, addr);
    cycle();
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1'b1;
      rdata  = {32'hD0D0_0000 | 32'(b), addr};
      rlast  = (b == nbeats - 1);
      rresp  = (b == resp_at) ? 2'b10 : 2'b00;
      rid    = (b == rid_at) ? 6'd5 : 6'(c);
      #1;
      chk("burst_rsp_valid", rsp_valid, 64'd1 << c);
      cycle();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  initial begin
    int exp_g[5];
    int b;
    logic [31:0] tmp;
    exp_g = '{0, 1, 2, 3, 0};
    idle_inputs();
    do_reset();
    chk("arsize", arsize, 3'b011);
    chk("arburst", arburst, 2'b01);
    chk("arlock", arlock, 2'b00);
    chk("arcache", arcache, 4'b0011);
    chk("arprot", arprot, 3'b000);
    chk("arqos", arqos, 4'b0000);

    // single request from client 2
    run_burst(2, 32'h1000_0040, 3, 4, -1, -1);
    chk("single_idle", arvalid, 64'd0);
    chk("single_err", err_sticky, 64'd0);

    // round robin with all clients requesting, single-beat bursts
    do_reset();
    req_valid = 4'hF; arready = 1'b1; rsp_ready = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", req_ready, 64'd1 << exp_g[k]);
      cycle();
      chk("rr_arid", arid, exp_g[k]);
      cycle();
      rvalid = 1'b1; rlast = 1'b1; rid = 6'(exp_g[k]); rdata = 64'(k);
      cycle();
      rvalid = 1'b0; rlast = 1'b0;
    end
    req_valid = 4'h0;

    // AR backpressure then toggling rsp_ready[1]
    do_reset();
    req_addr[32 +: 32] = 32'h3000_0100;
    req_len[4 +: 4] = 4'd3;
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      chk("bp_arvalid", arvalid, 64'd1);
      chk("bp_araddr", araddr, 32'h3000_0100);
      chk("bp_arid", arid, 64'd1);
      chk("bp_arlen", arlen, 64'd3);
      cycle();
    end
    arready = 1'b1;
    cycle();
    b = 0;
    for (int g = 0; g < 40 && b < 4; g++) begin
      rsp_ready = 4'($urandom);
      rsp_ready[1] = (g % 2 == 0);
      rvalid = 1'b1; rid = 6'd1; rlast = (b == 3);
      rdata = 64'hBEEF_0000_0000_0000 + 64'(b);
      #1;
      chk("bp_rready", rready, rsp_ready[1]);
      cycle();
      if (rsp_ready[1]) b++;
    end
    rvalid = 1'b0; rlast = 1'b0;
    chk("bp_beats", b, 64'd4);

    // error flags
    do_reset();
    run_burst(0, 32'h2000_0000, 3, 4, 1, -1);
    chk("err_resp", err_sticky, 3'b001);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("err_clr1", err_sticky, 3'b000);
    run_burst(0, 32'h2000_0040, 3, 4, -1, 0);
    chk("err_rid", err_sticky, 3'b010);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    run_burst(0, 32'h2000_0080, 3, 2, -1, -1);
    chk("err_last", err_sticky, 3'b100);
    chk("err_last_idle", arvalid, 64'd0);
    req_valid = 4'b0010;
    #1;
    chk("err_last_ready", req_ready, 4'b0010);
    req_valid = 4'b0000;
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("err_clr2", err_sticky, 3'b000);

    // reset in the middle of a burst, then client 3 scanned from pointer 0
    req_valid = 4'b0010; arready = 1'b1; rsp_ready = 4'hF;
    cycle();
    req_valid = 4'b0000;
    cycle();
    rvalid = 1'b1; rid = 6'd1; rlast = 1'b0; rdata = 64'h1234;
    #1;
    chk("mid_rsp_valid", rsp_valid, 4'b0010);
    do_reset();
    req_valid = 4'b1000;
    #1;
    chk("post_rst_ready", req_ready, 4'b1000);
    cycle();
    req_valid = 4'b0000;
    chk("post_rst_arid", arid, 64'd3);
    arready = 1'b1;
    cycle();
    rvalid = 1'b1; rid = 6'd3; rlast = 1'b1;
    cycle();
    rvalid = 1'b0; rlast = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      req_valid = 4'($urandom);
      for (int c = 0; c < N; c++) begin
        tmp = $urandom();
        tmp[2:0] = 3'b000;
        req_addr[c*32 +: 32] = tmp;
        req_len[c*4 +: 4] = 4'($urandom_range(0, 4));
      end
      arready   = ($urandom_range(0, 3) != 0);
      rsp_ready = 4'($urandom);
      rvalid    = ($urandom_range(0, 2) != 0);
      rdata     = {$urandom(), $urandom()};
      if (m_phase == 2)
        rlast = (((m_beats % 16) == m_len) ^ ($urandom_range(0, 19) == 0));
      else
        rlast = 1'($urandom_range(0, 1));
      rid     = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : 6'(m_grant);
      rresp   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      err_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
